// File: rtl/sudoku_timer_pkg.sv
// ----------------------------------------------------------------------------
// sudoku_timer_pkg
// Shared definitions for the puzzle-timer session controller:
//   - ctrl_state_t : session FSM state codes (IDLE..DONE)
//   - TIMER_RUN / TIMER_HOLD : timer control codes driven on timer_state
//   - BCD_ZERO / BCD_MAX     : packed-BCD mm:ss bounds
//   - bcd_faster()           : ordering of two packed-BCD mm:ss values
// ----------------------------------------------------------------------------
package sudoku_timer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } ctrl_state_t;

    localparam logic [1:0]  TIMER_RUN  = 2'd1;
    localparam logic [1:0]  TIMER_HOLD = 2'd2;

    localparam logic [15:0] BCD_ZERO   = 16'h0000;
    localparam logic [15:0] BCD_MAX    = 16'h9959;

    // Packed BCD keeps digit significance in bit order, so a plain unsigned
    // compare orders mm:ss values correctly.
    function automatic logic bcd_faster(input logic [15:0] cand,
                                        input logic [15:0] best);
        return cand < best;
    endfunction

endpackage

// File: rtl/sudoku_timer_ctrl_if.sv
// ----------------------------------------------------------------------------
// sudoku_timer_ctrl_if
// Signal bundle between the game/button logic + timer datapath (master) and
// the session controller (slave).
//   master drives : start_req, pause_req, solved, abort, time_spent
//   slave drives  : timer_clr, timer_state, ctrl_state, final_time,
//                   best_time, best_valid, new_record, timed_out, aborted
// ----------------------------------------------------------------------------
interface sudoku_timer_ctrl_if;

    logic        start_req;
    logic        pause_req;
    logic        solved;
    logic        abort;
    logic [15:0] time_spent;

    logic        timer_clr;
    logic [1:0]  timer_state;
    logic [2:0]  ctrl_state;
    logic [15:0] final_time;
    logic [15:0] best_time;
    logic        best_valid;
    logic        new_record;
    logic        timed_out;
    logic        aborted;

    modport master (
        output start_req, pause_req, solved, abort, time_spent,
        input  timer_clr, timer_state, ctrl_state, final_time,
               best_time, best_valid, new_record, timed_out, aborted
    );

    modport slave (
        input  start_req, pause_req, solved, abort, time_spent,
        output timer_clr, timer_state, ctrl_state, final_time,
               best_time, best_valid, new_record, timed_out, aborted
    );

endinterface

// File: rtl/best_time_tracker.sv
// ----------------------------------------------------------------------------
// best_time_tracker
// Keeps the fastest solved time across sessions.
//   clk, rst      : clock, asynchronous active-high reset
//   capture_i     : a session was solved this cycle; consider cand_i
//   cand_i        : candidate packed-BCD mm:ss time
//   best_time_o   : fastest solved time (BCD_MAX until a record exists)
//   best_valid_o  : best_time_o holds a real record
//   new_record_o  : one-cycle pulse, best_time_o updated on the last edge
// ----------------------------------------------------------------------------
module best_time_tracker
    import sudoku_timer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        capture_i,
    input  logic [15:0] cand_i,
    output logic [15:0] best_time_o,
    output logic        best_valid_o,
    output logic        new_record_o
);

    logic [15:0] best_time_q, best_time_d;
    logic        best_valid_q, best_valid_d;
    logic        new_record_q, new_record_d;

    always_comb begin
        best_time_d  = best_time_q;
        best_valid_d = best_valid_q;
        new_record_d = 1'b0;
        // A tie with the current best is not a new record.
        if (capture_i && (!best_valid_q || bcd_faster(cand_i, best_time_q))) begin
            best_time_d  = cand_i;
            best_valid_d = 1'b1;
            new_record_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_time_q  <= BCD_MAX;
            best_valid_q <= 1'b0;
            new_record_q <= 1'b0;
        end else begin
            best_time_q  <= best_time_d;
            best_valid_q <= best_valid_d;
            new_record_q <= new_record_d;
        end
    end

    assign best_time_o  = best_time_q;
    assign best_valid_o = best_valid_q;
    assign new_record_o = new_record_q;

endmodule

// File: rtl/sudoku_timer_ctrl.sv
// ----------------------------------------------------------------------------
// sudoku_timer_ctrl
// Session controller for the puzzle timer: IDLE -> CLEAR -> RUN <-> PAUSE ->
// DONE. Drives the timer clear/hold controls, enforces TIME_LIMIT on the
// running time, captures the final time and tracks the best solved time.
//   clk, rst : clock, asynchronous active-high reset
//   ctrl_if  : slave side of sudoku_timer_ctrl_if (requests + time_spent in,
//              timer controls, state, captured times and flags out)
// Parameter TIME_LIMIT: packed-BCD mm:ss at or above which RUN times out.
// ----------------------------------------------------------------------------
module sudoku_timer_ctrl
    import sudoku_timer_pkg::*;
#(
    parameter logic [15:0] TIME_LIMIT = BCD_MAX
) (
    input  logic               clk,
    input  logic               rst,
    sudoku_timer_ctrl_if.slave ctrl_if
);

    ctrl_state_t state_q, state_d;
    logic        timer_clr_q, timer_clr_d;
    logic [1:0]  timer_state_q, timer_state_d;
    logic [15:0] final_time_q, final_time_d;
    logic        timed_out_q, timed_out_d;
    logic        aborted_q, aborted_d;
    logic        solve_capture;

    always_comb begin
        state_d       = state_q;
        final_time_d  = final_time_q;
        timed_out_d   = timed_out_q;
        aborted_d     = aborted_q;
        solve_capture = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (ctrl_if.start_req) begin
                    state_d     = ST_CLEAR;
                    timed_out_d = 1'b0;
                    aborted_d   = 1'b0;
                end
            end
            ST_CLEAR: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ctrl_if.abort) begin
                    state_d      = ST_DONE;
                    aborted_d    = 1'b1;
                    final_time_d = ctrl_if.time_spent;
                end else if (ctrl_if.solved) begin
                    state_d       = ST_DONE;
                    final_time_d  = ctrl_if.time_spent;
                    solve_capture = 1'b1;
                end else if (ctrl_if.time_spent >= TIME_LIMIT) begin
                    state_d      = ST_DONE;
                    timed_out_d  = 1'b1;
                    final_time_d = ctrl_if.time_spent;
                end else if (ctrl_if.pause_req) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (ctrl_if.abort) begin
                    state_d      = ST_DONE;
                    aborted_d    = 1'b1;
                    final_time_d = ctrl_if.time_spent;
                end else if (ctrl_if.pause_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Timer controls are decoded from the next state so they change on
        // the same edge as the FSM and stay glitch-free registered outputs.
        timer_clr_d   = (state_d == ST_CLEAR);
        timer_state_d = (state_d == ST_RUN) ? TIMER_RUN : TIMER_HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            timer_clr_q   <= 1'b0;
            timer_state_q <= TIMER_HOLD;
            final_time_q  <= BCD_ZERO;
            timed_out_q   <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_clr_q   <= timer_clr_d;
            timer_state_q <= timer_state_d;
            final_time_q  <= final_time_d;
            timed_out_q   <= timed_out_d;
            aborted_q     <= aborted_d;
        end
    end

    best_time_tracker u_best (
        .clk          (clk),
        .rst          (rst),
        .capture_i    (solve_capture),
        .cand_i       (ctrl_if.time_spent),
        .best_time_o  (ctrl_if.best_time),
        .best_valid_o (ctrl_if.best_valid),
        .new_record_o (ctrl_if.new_record)
    );

    assign ctrl_if.timer_clr   = timer_clr_q;
    assign ctrl_if.timer_state = timer_state_q;
    assign ctrl_if.ctrl_state  = state_q;
    assign ctrl_if.final_time  = final_time_q;
    assign ctrl_if.timed_out   = timed_out_q;
    assign ctrl_if.aborted     = aborted_q;

endmodule

// File: doc/sudoku_timer_ctrl.md
Name: sudoku_timer_ctrl

Overview:
Session controller for the puzzle timer. It sequences the game timer through idle, clear, run, pause and done. It drives the timer's clear and hold controls, and it enforces a time limit on the packed-BCD mm:ss value the timer returns. It also records the final time and the best solve time for the display logic. It sits between the game FSM/button logic and the timer datapath.

Parameters:
TIME_LIMIT, 16'h9959, packed BCD mm:ss at or above which a running session times out.

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start_req  input  1  one-cycle pulse: start a new session
pause_req  input  1  one-cycle pulse: toggle pause/resume
solved  input  1  one-cycle pulse: board verified correct
abort  input  1  one-cycle pulse: give up the current session
time_spent  input  16  packed BCD {mXX,mX,sXX,sX} from the timer
timer_clr  output  1  registered one-cycle clear to the timer; ORed with rst at the timer's reset input
timer_state  output  2  timer control: 2'd1 = count, 2'd2 = hold
ctrl_state  output  3  current FSM state
final_time  output  16  time_spent captured at session end
best_time  output  16  fastest solved time
best_valid  output  1  best_time holds a real record
new_record  output  1  one-cycle pulse: best_time updated this cycle
timed_out  output  1  last session ended by limit
aborted  output  1  last session ended by abort

Behaviour:
- Reset values: FSM IDLE; timer_clr 0; timer_state 2'd2; final_time 0; best_time 16'h9959; best_valid 0; new_record 0; timed_out 0; aborted 0.
- State encoding: IDLE=0, CLEAR=1, RUN=2, PAUSE=3, DONE=4. All other codes return to IDLE on the next clock.
- timer_state is registered. It is 2'd1 only while the FSM is in RUN and 2'd2 in every other state, so the timer never counts outside RUN.
- IDLE: start_req -> CLEAR. All other inputs are ignored.
- CLEAR: timer_clr=1 for exactly this one cycle. Next state is RUN unconditionally. Entering CLEAR zeroes timed_out and aborted.
- RUN: evaluate events in priority order abort > solved > limit > pause_req.
  - abort -> DONE; aborted=1; final_time<=time_spent; no record update.
  - solved -> DONE; final_time<=time_spent. If !best_valid or time_spent < best_time (unsigned compare, valid for packed BCD): best_time<=time_spent, best_valid<=1, new_record=1 for one cycle.
  - time_spent >= TIME_LIMIT -> DONE; timed_out=1; final_time<=time_spent.
  - pause_req -> PAUSE.
  - start_req is ignored.
- PAUSE: abort beats pause_req.
  - abort -> DONE as in RUN.
  - pause_req -> RUN.
  - solved and start_req are ignored; the limit is not checked.
- DONE: start_req -> CLEAR (new session; best_time and best_valid persist). All other inputs are ignored.
- Latency: event pulse at edge N -> state, flags and capture visible after edge N. timer_state changes after the same edge.
- The value captured is the time_spent present on the event cycle. A timer increment on that same edge is not reflected.
- Equal time to best: no update, no new_record.
- rst mid-session: immediate return to reset values. Records are lost.

Decomposition:
- Shared package sudoku_timer_pkg:
  - FSM state localparams (IDLE..DONE).
  - TIMER_RUN=2'd1 and TIMER_HOLD=2'd2.
  - BCD_ZERO=16'h0000 and BCD_MAX=16'h9959.
- One sub-module, best_time_tracker: holds best_time, best_valid and new_record. Inputs are a capture strobe and a candidate time. It contains the compare.
- The FSM and flags stay in sudoku_timer_ctrl.

Test Plan:
- Reset, then start_req -> timer_clr high for exactly 1 cycle, ctrl_state 1 then 2, timer_state 2'd1 from the cycle after CLEAR.
- In RUN with time_spent=16'h0125, solved -> DONE, final_time=16'h0125, best_time=16'h0125, best_valid=1, new_record for 1 cycle, timer_state=2'd2.
- Restart, solved at 16'h0210 -> best_time stays 16'h0125, no new_record. Restart, solved at 16'h0059 -> best_time=16'h0059, new_record pulses.
- TIME_LIMIT=16'h0005: run until time_spent=16'h0005 -> DONE, timed_out=1, final_time=16'h0005, best unchanged.
- pause_req in RUN -> PAUSE with timer_state=2'd2. solved while paused -> ignored. pause_req -> RUN. abort and solved in the same cycle -> DONE, aborted=1, no record.
- rst asserted in PAUSE with best_valid=1 -> all outputs return to reset values asynchronously. start_req in RUN is ignored.
